// File: rtl/ds_pkg.sv
// Shared constants for the multi-channel delta-sigma DAC: integrator guard bits,
// saturation limit and per-channel LFSR seeds (used only when DS_DITHER_EN is defined).
package ds_pkg;

  localparam int GUARD_BITS = 4;

  // Integrators saturate at +/-2^(WIDTH+2), two bits inside their WIDTH+4 range.
  function automatic int sat_limit(input int width);
    return 1 << (width + GUARD_BITS - 2);
  endfunction

  // Low bytes are all distinct and nonzero, so folding the bank index into the
  // high byte keeps every seed nonzero and unique for any channel count.
  localparam logic [15:0] LFSR_SEEDS [8] = '{
    16'hACE1, 16'h5A3B, 16'h1F72, 16'hC3A4, 16'h7E15, 16'h2B96, 16'h9D47, 16'h40C8
  };

  function automatic logic [15:0] lfsr_seed(input int ch);
    return LFSR_SEEDS[ch % 8] ^ 16'((ch / 8) << 8);
  endfunction

endpackage

// File: rtl/ds_mod_core.sv
// One delta-sigma modulator channel: 1st/2nd-order saturating integrators and a
// 1-bit quantizer; DS_DITHER_EN adds 4-bit LFSR dither ahead of the comparator.
module ds_mod_core
  import ds_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ORDER = 2
`ifdef DS_DITHER_EN
  ,
  parameter logic [15:0] SEED = 16'hACE1
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] x,
  output logic                    pdm
);

  localparam int AW = WIDTH + GUARD_BITS;
  localparam int EW = AW + 1;
  localparam logic signed [EW-1:0] LIM_P = EW'(sat_limit(WIDTH));
  localparam logic signed [EW-1:0] LIM_N = -LIM_P;
  localparam logic signed [EW-1:0] FB_P  = EW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] FB_N  = -EW'(1 << (WIDTH - 1));

  logic signed [AW-1:0] i0, i1;
  logic signed [EW-1:0] fb, i0_new, i1_new, cmp;

  function automatic logic signed [EW-1:0] sat(input logic signed [EW-1:0] v);
    if (v > LIM_P) return LIM_P;
    if (v < LIM_N) return LIM_N;
    return v;
  endfunction

`ifdef DS_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst)     lfsr <= SEED;
    else if (en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    fb     = pdm ? FB_P : FB_N;
    i0_new = sat({i0[AW-1], i0} + {{(EW - WIDTH){x[WIDTH-1]}}, x} - fb);
    i1_new = sat({i1[AW-1], i1} + i0_new - fb);
    cmp    = (ORDER == 2) ? i1_new : i0_new;
`ifdef DS_DITHER_EN
    cmp    = cmp + {{(EW - 4){lfsr[3]}}, lfsr[3:0]};
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers
    // sample the pre-edge values regardless of statement order.
    if (rst) begin
      i0  <= '0;
      i1  <= '0;
      pdm <= 1'b0;
    end else if (!en) begin
      // Muted: clear the loop and emit a zero-mean 0101 idle pattern.
      i0  <= '0;
      i1  <= '0;
      pdm <= ~pdm;
    end else begin
      i0  <= i0_new[AW-1:0];
      i1  <= (ORDER == 2) ? i1_new[AW-1:0] : '0;
      pdm <= (cmp > 0);
    end
  end

endmodule

// File: rtl/delta_sigma_dac_mc.sv
// Multi-channel delta-sigma DAC: shared OSR phase counter, pending/active sample
// handshake and one ds_mod_core per channel. Optional dither: DS_DITHER_EN.
module delta_sigma_dac_mc
  import ds_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int OSR      = 64,
  parameter int ORDER    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [CHANNELS-1:0]       pdm_out,
  output logic                      sample_tick,
  output logic                      underrun
);

  localparam int CW = $clog2(OSR);

  logic [CW-1:0]               phase;
  logic                        pending_full;
  logic [CHANNELS*WIDTH-1:0]   pending, active;
  logic                        xfer, tick;

  assign s_ready     = !pending_full;
  assign xfer        = s_valid && s_ready;
  assign tick        = en && (phase == CW'(OSR - 1));
  assign sample_tick = tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      pending_full <= 1'b0;
      active       <= '0;
      underrun     <= 1'b0;
    end else begin
      phase <= en ? phase + CW'(1) : '0;
      if (tick && pending_full) active <= pending;
      // A transfer only happens while pending is empty, so it never collides
      // with the tick draining a full pending register.
      if (xfer)      pending_full <= 1'b1;
      else if (tick) pending_full <= 1'b0;
      if (!en)                      underrun <= 1'b0;
      else if (tick && !pending_full) underrun <= 1'b1;
    end
  end

  // NOTE: the pending data register has no reset; pending_full qualifies it.
  always_ff @(posedge clk) begin
    if (xfer) pending <= s_data;
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
`ifdef DS_DITHER_EN
    ds_mod_core #(.WIDTH(WIDTH), .ORDER(ORDER), .SEED(lfsr_seed(ch))) u_core (
`else
    ds_mod_core #(.WIDTH(WIDTH), .ORDER(ORDER)) u_core (
`endif
      .clk (clk),
      .rst (rst),
      .en  (en),
      .x   (active[ch*WIDTH +: WIDTH]),
      .pdm (pdm_out[ch])
    );
  end

endmodule

// File: tb/tb_delta_sigma_dac_mc.sv
// Directed bench for delta_sigma_dac_mc (WIDTH=16, CHANNELS=2, OSR=64, ORDER=2).
module tb_delta_sigma_dac_mc;

  localparam int W = 16;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           rst, en, s_valid;
  logic [C*W-1:0] s_data;
  logic           s_ready, sample_tick, underrun;
  logic [C-1:0]   pdm_out;

  int n_tests = 0;
  int n_fail  = 0;

  delta_sigma_dac_mc #(.WIDTH(W), .CHANNELS(C), .OSR(64), .ORDER(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .pdm_out     (pdm_out),
    .sample_tick (sample_tick),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    n_tests++;
    if (got > exp + tol || got < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic logic [C*W-1:0] pack(input int a, input int b);
    logic [31:0] av, bv;
    av = a;
    bv = b;
    return {bv[W-1:0], av[W-1:0]};
  endfunction

  function automatic int act(input int ch);
    logic [W-1:0] v;
    v = dut.active[ch*W +: W];
    return int'($signed(v));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until sample_tick is seen in the current cycle; n = cycles waited.
  task automatic wait_tick(output int n);
    n = 0;
    while (!sample_tick && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, toggles, c0, c1_tot, c0_min, c0_max, neg0, neg1;
    logic [C-1:0] prev;

    // Reset overrides en and a pending transfer.
    rst = 1'b1; en = 1'b1; s_valid = 1'b1; s_data = pack(5, 5);
    step(); step();
    check("rst_pdm", pdm_out, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ready", s_ready, 1);
    check("rst_active", act(0), 0);

    // Back-to-back samples 1,2,3 with s_valid held high.
    rst = 1'b0; s_data = pack(1, -1);
    step();
    check("ready_low_after_xfer", s_ready, 0);
    s_data = pack(2, -2);
    for (int k = 1; k <= 3; k++) begin
      wait_tick(n);
      check($sformatf("tick%0d_wait", k), n, 62);
      step();
      check($sformatf("active%0d_ch0", k), act(0), k);
      check($sformatf("active%0d_ch1", k), act(1), -k);
      check($sformatf("ready_after_tick%0d", k), s_ready, 1);
      step();
      check($sformatf("refill%0d", k), s_ready, 0);
      s_data = pack(k + 2, -(k + 2));
    end

    // Starve the input: sample 4 plays, then the next boundary underruns.
    s_valid = 1'b0;
    wait_tick(n);
    step();
    check("active4_ch0", act(0), 4);
    check("no_underrun_yet", underrun, 0);
    wait_tick(n);
    check("starve_tick_wait", n, 63);
    check("underrun_before_edge", underrun, 0);
    step();
    check("underrun_set", underrun, 1);
    check("active_held", act(0), 4);
    step();
    check("underrun_sticky", underrun, 1);

    // Mute for 10 clocks: idle toggling, underrun clears, handshake still live.
    prev = pdm_out;
    toggles = 0;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        s_valid = 1'b1;
        s_data = pack(7, -7);
      end
      step();
      if (pdm_out == ~prev) toggles++;
      prev = pdm_out;
      if (i == 0) check("underrun_clear_on_mute", underrun, 0);
      if (i == 4) check("tick_low_when_muted", sample_tick, 0);
    end
    check("idle_toggles", toggles, 10);
    check("xfer_while_muted", s_ready, 0);
    s_valid = 1'b0;
    en = 1'b1;
    wait_tick(n);
    check("tick_after_unmute", n, 63);
    step();
    check("active_after_unmute", act(1), -7);

    // Reset at phase 30 with pending full discards everything.
    s_valid = 1'b1; s_data = pack(9, -9);
    step();
    s_data = pack(11, -11);
    repeat (29) step();
    check("pending_full_pre_rst", s_ready, 0);
    rst = 1'b1;
    step();
    check("mid_rst_pdm", pdm_out, 0);
    check("mid_rst_tick", sample_tick, 0);
    check("mid_rst_ready", s_ready, 1);
    check("mid_rst_active", act(0), 0);
    rst = 1'b0; s_valid = 1'b0;
    wait_tick(n);
    check("tick_after_rst", n, 63);
    step();
    check("pending_discarded", act(0), 0);
    check("underrun_after_rst", underrun, 1);

    // DC densities: ch0 = 0 (per-window), ch1 = +16383 (long window).
    rst = 1'b1;
    step();
    rst = 1'b0; s_valid = 1'b1; s_data = pack(0, 16383);
    repeat (640) step();
    c1_tot = 0; c0_min = 64; c0_max = 0;
    for (int w = 0; w < 16; w++) begin
      c0 = 0;
      for (int i = 0; i < 64; i++) begin
        step();
        c0 += int'(pdm_out[0]);
        c1_tot += int'(pdm_out[1]);
      end
      if (c0 < c0_min) c0_min = c0;
      if (c0 > c0_max) c0_max = c0;
    end
    check("dc0_window_min", c0_min, 32, 1);
    check("dc0_window_max", c0_max, 32, 1);
    check("dc_half_ones_1024", c1_tot, 768, 20);

    // Negative full scale on both channels: output pinned low, no wrap bursts.
    s_data = pack(-32768, -32768);
    repeat (512) step();
    neg0 = 0; neg1 = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      neg0 += int'(pdm_out[0]);
      neg1 += int'(pdm_out[1]);
    end
    check("neg_fs_ch0_ones", neg0, 0, 10);
    check("neg_fs_ch1_ones", neg1, 0, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
